// File: rtl/rv_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_lsu_pkg
// Brief    : Shared types and encodings for the RV32I load/store unit.
// Revision : 1.0 - initial release
// ============================================================================
package rv_lsu_pkg;

    // Handshake FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_t;

    // Access size encodings carried in funct3[1:0]
    localparam logic [1:0] LSU_B = 2'd0;
    localparam logic [1:0] LSU_H = 2'd1;
    localparam logic [1:0] LSU_W = 2'd2;
    localparam logic [1:0] LSU_D = 2'd3;

    // funct3 field positions
    localparam int F3_SIZE_LO = 0;
    localparam int F3_SIZE_HI = 1;
    localparam int F3_UNS     = 2;

endpackage
`default_nettype wire

// File: rtl/rv_lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : rv_lsu_align
// Brief    : Combinational lane alignment: byte enables, store shift,
//            load shift/extension and misalign/illegal-size detection.
// Revision : 1.0 - initial release
// ============================================================================
module rv_lsu_align
    import rv_lsu_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    localparam int NB         = DATA_WIDTH / 8,
    localparam int OFFW       = $clog2(NB)
) (
    input  logic [2:0]            funct3_i,
    input  logic [OFFW-1:0]       off_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic [NB-1:0]         be_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  misaligned_o,
    output logic                  illegal_o
);

    logic [1:0]            w_size;
    logic                  w_uns;
    logic [7:0]            w_be_base;
    logic [OFFW-1:0]       w_off_mask;
    logic [OFFW+2:0]       w_shamt;
    logic [DATA_WIDTH-1:0] w_sh;

    assign w_size  = funct3_i[F3_SIZE_HI:F3_SIZE_LO];
    assign w_uns   = funct3_i[F3_UNS];
    assign w_shamt = {off_i, 3'b000};

    // Per-size base lane mask and the offset bits that must be zero
    always_comb begin
        w_be_base  = 8'h01;
        w_off_mask = '0;
        case (w_size)
            LSU_B:   begin w_be_base = 8'h01; w_off_mask = '0;         end
            LSU_H:   begin w_be_base = 8'h03; w_off_mask = OFFW'(1);   end
            LSU_W:   begin w_be_base = 8'h0F; w_off_mask = OFFW'(3);   end
            default: begin w_be_base = 8'hFF; w_off_mask = OFFW'(7);   end
        endcase
    end

    assign be_o         = NB'(w_be_base) << off_i;
    assign wdata_o      = wdata_i << w_shamt;
    assign misaligned_o = |(off_i & w_off_mask);
    // A doubleword cannot be carried on a 32-bit bus
    assign illegal_o    = (w_size == LSU_D) && (DATA_WIDTH < 64);
    assign w_sh         = rdata_i >> w_shamt;

    // Extend the shifted load data from the top bit of the accessed size
    always_comb begin
        rdata_o = w_sh;
        case (w_size)
            LSU_B: begin
                if (w_uns) rdata_o = DATA_WIDTH'(w_sh[7:0]);
                else       rdata_o = DATA_WIDTH'($signed(w_sh[7:0]));
            end
            LSU_H: begin
                if (w_uns) rdata_o = DATA_WIDTH'(w_sh[15:0]);
                else       rdata_o = DATA_WIDTH'($signed(w_sh[15:0]));
            end
            LSU_W: begin
                // On a 32-bit bus the casts are identities: full width, no extension
                if (w_uns) rdata_o = DATA_WIDTH'(w_sh[31:0]);
                else       rdata_o = DATA_WIDTH'($signed(w_sh[31:0]));
            end
            default: rdata_o = w_sh;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rv_lsu_handshake.sv
`default_nettype none
// ============================================================================
// Module   : rv_lsu_handshake
// Brief    : Load/store unit bridging the RV32I core to a variable-latency
//            data memory over a req/gnt/rvalid handshake, with timeout.
// Revision : 1.0 - initial release
// ============================================================================
module rv_lsu_handshake
    import rv_lsu_pkg::*;
#(
    parameter  int DATA_WIDTH     = 32,
    parameter  int ADDR_WIDTH     = 32,
    parameter  int TIMEOUT_CYCLES = 255,
    localparam int NB             = DATA_WIDTH / 8,
    localparam int OFFW           = $clog2(NB)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  busy_o,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  DMEM_req_o,
    output logic                  DMEM_we_o,
    output logic [ADDR_WIDTH-1:0] DMEM_addr_o,
    output logic [DATA_WIDTH-1:0] DMEM_wr_data_o,
    output logic [NB-1:0]         DMEM_wr_byte_en_o,
    input  logic                  DMEM_gnt_i,
    input  logic                  DMEM_rvalid_i,
    input  logic [DATA_WIDTH-1:0] DMEM_rd_data_i,
    input  logic                  DMEM_err_i
);

    // Counter only has to reach TIMEOUT_CYCLES-1
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    lsu_state_t            state_q, state_d;
    logic                  we_q, we_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  w_idle;
    logic                  w_in_req;
    logic                  w_timeout;
    logic [2:0]            w_al_funct3;
    logic [OFFW-1:0]       w_al_off;
    logic [NB-1:0]         w_be;
    logic [DATA_WIDTH-1:0] w_st_data;
    logic [DATA_WIDTH-1:0] w_ld_data;
    logic                  w_misaligned;
    logic                  w_illegal;

    assign w_idle   = (state_q == ST_IDLE);
    assign w_in_req = (state_q == ST_REQ);

    // In IDLE the aligner classifies the incoming request; afterwards it
    // works on the captured copy so DMEM outputs stay stable.
    assign w_al_funct3 = w_idle ? req_funct3_i : funct3_q;
    assign w_al_off    = w_idle ? req_addr_i[OFFW-1:0] : addr_q[OFFW-1:0];

    rv_lsu_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .funct3_i     (w_al_funct3),
        .off_i        (w_al_off),
        .wdata_i      (wdata_q),
        .rdata_i      (DMEM_rd_data_i),
        .be_o         (w_be),
        .wdata_o      (w_st_data),
        .rdata_o      (w_ld_data),
        .misaligned_o (w_misaligned),
        .illegal_o    (w_illegal)
    );

    assign w_timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

    // Next-state, capture, timeout and response-data logic
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rdata_d  = '0;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    we_d     = req_we_i;
                    funct3_d = req_funct3_i;
                    addr_d   = req_addr_i;
                    wdata_d  = req_wdata_i;
                    if (w_misaligned || w_illegal) begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                        cnt_d   = '0;
                    end
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (w_timeout) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                end else if (DMEM_gnt_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Completion wins over a timeout expiring in the same cycle
                if (DMEM_rvalid_i) begin
                    state_d = ST_RESP;
                    err_d   = DMEM_err_i;
                    if (!DMEM_err_i && !we_q) rdata_d = w_ld_data;
                end else if (w_timeout) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and capture registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign busy_o            = !w_idle;
    assign rsp_valid_o       = (state_q == ST_RESP);
    assign rsp_rdata_o       = rdata_q;
    assign rsp_err_o         = err_q;
    assign DMEM_req_o        = w_in_req;
    assign DMEM_we_o         = w_in_req && we_q;
    assign DMEM_addr_o       = w_in_req ? {addr_q[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}} : '0;
    assign DMEM_wr_data_o    = (w_in_req && we_q) ? w_st_data : '0;
    assign DMEM_wr_byte_en_o = w_in_req ? (we_q ? w_be : '1) : '0;

endmodule
`default_nettype wire

// File: tb/tb_rv_lsu_handshake.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_lsu_handshake
// Brief    : Self-checking bench for rv_lsu_handshake (32-bit with a short
//            timeout, plus a 64-bit instance for doubleword accesses).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rv_lsu_handshake;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 32-bit instance, TIMEOUT_CYCLES = 8
    logic        req_valid, req_we;
    logic [2:0]  req_f3;
    logic [31:0] req_addr, req_wdata;
    logic        busy, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        m_req, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    logic        gnt, rvalid, derr;
    logic [31:0] rd_data;

    // 64-bit instance, timeout disabled
    logic        x_req_valid, x_req_we;
    logic [2:0]  x_req_f3;
    logic [31:0] x_req_addr;
    logic [63:0] x_req_wdata;
    logic        x_busy, x_rsp_valid, x_rsp_err;
    logic [63:0] x_rsp_rdata;
    logic        x_m_req, x_m_we;
    logic [31:0] x_m_addr;
    logic [63:0] x_m_wdata;
    logic [7:0]  x_m_be;
    logic        x_gnt, x_rvalid, x_derr;
    logic [63:0] x_rd_data;

    int n_checks = 0;
    int n_err    = 0;

    rv_lsu_handshake #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_we_i(req_we), .req_funct3_i(req_f3),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .busy_o(busy), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .DMEM_req_o(m_req), .DMEM_we_o(m_we), .DMEM_addr_o(m_addr),
        .DMEM_wr_data_o(m_wdata), .DMEM_wr_byte_en_o(m_be),
        .DMEM_gnt_i(gnt), .DMEM_rvalid_i(rvalid), .DMEM_rd_data_i(rd_data), .DMEM_err_i(derr)
    );

    rv_lsu_handshake #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(0)) dut64 (
        .clk(clk), .rst(rst),
        .req_valid_i(x_req_valid), .req_we_i(x_req_we), .req_funct3_i(x_req_f3),
        .req_addr_i(x_req_addr), .req_wdata_i(x_req_wdata),
        .busy_o(x_busy), .rsp_valid_o(x_rsp_valid), .rsp_rdata_o(x_rsp_rdata), .rsp_err_o(x_rsp_err),
        .DMEM_req_o(x_m_req), .DMEM_we_o(x_m_we), .DMEM_addr_o(x_m_addr),
        .DMEM_wr_data_o(x_m_wdata), .DMEM_wr_byte_en_o(x_m_be),
        .DMEM_gnt_i(x_gnt), .DMEM_rvalid_i(x_rvalid), .DMEM_rd_data_i(x_rd_data), .DMEM_err_i(x_derr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference load result: pick the addressed bytes, then sign- or zero-extend
    function automatic logic [31:0] ref_load(input int sz, input bit uns, input int off,
                                             input logic [31:0] d);
        longint unsigned v, mask;
        int nb;
        nb   = 1 << sz;
        v    = longint'(d) >> (8 * off);
        mask = (64'd1 << (8 * nb)) - 64'd1;
        v    = v & mask;
        if (!uns && nb < 4 && (((v >> (8 * nb - 1)) & 64'd1) != 64'd0)) v = v | ~mask;
        return v[31:0];
    endfunction

    // One complete access on the 32-bit instance; gdly/rdly are idle cycles
    // before grant / rvalid. Random rvalid noise is driven while in REQ.
    task automatic txn32(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdat,
                         input int gdly, input int rdly, input bit e,
                         output logic [31:0] got);
        int sz, nb, off, t;
        bit bad;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_rd;
        sz     = int'(f3[1:0]);
        nb     = 1 << sz;
        off    = int'(addr[1:0]);
        bad    = (sz == 3) || ((off % nb) != 0);
        t      = ((1 << nb) - 1) << off;
        exp_be = we ? t[3:0] : 4'hF;
        exp_wd = wdata << (8 * off);
        exp_rd = (e || we) ? 32'h0 : ref_load(sz, f3[2], off, rdat);

        req_valid = 1'b1; req_we = we; req_f3 = f3; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        if (bad) begin
            chk("bad_rsp_valid", rsp_valid, 1'b1);
            chk("bad_rsp_err", rsp_err, 1'b1);
            chk("bad_rsp_rdata", rsp_rdata, 32'h0);
            chk("bad_no_dmem_req", m_req, 1'b0);
            got = rsp_rdata;
            req_valid = 1'b0;
            @(negedge clk);
            chk("bad_idle_after", busy, 1'b0);
            chk("bad_single_pulse", rsp_valid, 1'b0);
            return;
        end
        for (int i = 0; i <= gdly; i++) begin
            chk("req_high", m_req, 1'b1);
            chk("req_addr", m_addr, addr & 32'hFFFF_FFFC);
            chk("req_be", m_be, exp_be);
            chk("req_we", m_we, we);
            if (we) chk("req_wdata", m_wdata, exp_wd);
            chk("req_no_rsp", rsp_valid, 1'b0);
            gnt     = (i == gdly);
            rvalid  = 1'($urandom_range(0, 1));
            derr    = 1'($urandom_range(0, 1));
            rd_data = $urandom;
            @(negedge clk);
        end
        gnt = 1'b0;
        for (int j = 0; j <= rdly; j++) begin
            chk("wait_req_low", m_req, 1'b0);
            chk("wait_no_rsp", rsp_valid, 1'b0);
            chk("wait_busy", busy, 1'b1);
            rvalid  = (j == rdly);
            derr    = (j == rdly) ? e : 1'($urandom_range(0, 1));
            rd_data = (j == rdly) ? rdat : $urandom;
            @(negedge clk);
        end
        rvalid = 1'b0; derr = 1'b0;
        chk("rsp_valid", rsp_valid, 1'b1);
        chk("rsp_err", rsp_err, e);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        got = rsp_rdata;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rsp_single_pulse", rsp_valid, 1'b0);
        chk("idle_after", busy, 1'b0);
    endtask

    // Load on the 64-bit instance with immediate grant and rvalid
    task automatic txn64(input logic [2:0] f3, input logic [31:0] addr, input logic [63:0] rdat,
                         input bit exp_err, input logic [63:0] exp_rd);
        x_req_valid = 1'b1; x_req_we = 1'b0; x_req_f3 = f3; x_req_addr = addr; x_req_wdata = '0;
        @(negedge clk);
        if (exp_err) begin
            chk("x_err_rsp_valid", x_rsp_valid, 1'b1);
            chk("x_err_rsp_err", x_rsp_err, 1'b1);
            chk("x_err_no_req", x_m_req, 1'b0);
        end else begin
            chk("x_req_high", x_m_req, 1'b1);
            chk("x_req_addr", x_m_addr, addr & 32'hFFFF_FFF8);
            chk("x_req_be", x_m_be, 8'hFF);
            x_gnt = 1'b1;
            @(negedge clk);
            x_gnt = 1'b0; x_rvalid = 1'b1; x_rd_data = rdat;
            @(negedge clk);
            x_rvalid = 1'b0;
            chk("x_rsp_valid", x_rsp_valid, 1'b1);
            chk("x_rsp_err", x_rsp_err, 1'b0);
            chk("x_rsp_rdata", x_rsp_rdata, exp_rd);
        end
        x_req_valid = 1'b0;
        @(negedge clk);
        chk("x_idle_after", x_busy, 1'b0);
    endtask

    // Global watchdog so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion, expected finish before 500us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] got;
        rst = 1'b1;
        req_valid = 0; req_we = 0; req_f3 = 0; req_addr = 0; req_wdata = 0;
        gnt = 0; rvalid = 0; derr = 0; rd_data = 0;
        x_req_valid = 0; x_req_we = 0; x_req_f3 = 0; x_req_addr = 0; x_req_wdata = 0;
        x_gnt = 0; x_rvalid = 0; x_derr = 0; x_rd_data = 0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_dmem_req", m_req, 1'b0);
        chk("rst_dmem_be", m_be, 4'h0);
        chk("rst_dmem_addr", m_addr, 32'h0);
        chk("rst_x_dmem_req", x_m_req, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // LW 0x104, minimum latency
        txn32(1'b0, 3'b010, 32'h104, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0, got);
        chk("lw_data", got, 32'hDEADBEEF);
        // LB / LBU 0x103, LHU 0x102
        txn32(1'b0, 3'b000, 32'h103, 32'h0, 32'h80123456, 0, 0, 1'b0, got);
        chk("lb_data", got, 32'hFFFFFF80);
        txn32(1'b0, 3'b100, 32'h103, 32'h0, 32'h80123456, 1, 1, 1'b0, got);
        chk("lbu_data", got, 32'h00000080);
        txn32(1'b0, 3'b101, 32'h102, 32'h0, 32'h80123456, 0, 2, 1'b0, got);
        chk("lhu_data", got, 32'h00008012);
        // SH 0x102: lanes checked in REQ, rdata 0 after ack
        txn32(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'hFFFFFFFF, 0, 0, 1'b0, got);
        // Misaligned LW, illegal LD on 32-bit bus
        txn32(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 0, 1'b0, got);
        txn32(1'b0, 3'b011, 32'h108, 32'h0, 32'h0, 0, 0, 1'b0, got);
        // Grant withheld 3 cycles, then bus error
        txn32(1'b0, 3'b010, 32'h300, 32'h0, 32'h55AA55AA, 3, 0, 1'b1, got);

        // Timeout: no grant, error response in cycle 9, late rvalid ignored
        req_valid = 1'b1; req_we = 1'b0; req_f3 = 3'b010; req_addr = 32'h200;
        @(negedge clk);
        for (int c = 1; c <= 8; c++) begin
            chk("to_req_high", m_req, 1'b1);
            chk("to_no_rsp", rsp_valid, 1'b0);
            @(negedge clk);
        end
        chk("to_rsp_valid", rsp_valid, 1'b1);
        chk("to_rsp_err", rsp_err, 1'b1);
        chk("to_rsp_rdata", rsp_rdata, 32'h0);
        req_valid = 1'b0; rvalid = 1'b1; rd_data = 32'h12345678;
        @(negedge clk);
        chk("to_late_rvalid_1", rsp_valid, 1'b0);
        @(negedge clk);
        chk("to_late_rvalid_2", rsp_valid, 1'b0);
        chk("to_late_idle", busy, 1'b0);
        rvalid = 1'b0;

        // Reset while in REQ
        req_valid = 1'b1; req_f3 = 3'b010; req_addr = 32'h400;
        @(negedge clk);
        chk("rreq_req_high", m_req, 1'b1);
        rst = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        chk("rreq_req_low", m_req, 1'b0);
        chk("rreq_idle", busy, 1'b0);
        rst = 1'b0;

        // Reset while in WAIT, following rvalid produces no response
        req_valid = 1'b1; req_f3 = 3'b010; req_addr = 32'h404;
        @(negedge clk);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        chk("rwait_in_wait", busy, 1'b1);
        rst = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        chk("rwait_req_low", m_req, 1'b0);
        chk("rwait_idle", busy, 1'b0);
        rst = 1'b0; rvalid = 1'b1; rd_data = 32'hCAFEF00D;
        @(negedge clk);
        chk("rwait_no_rsp_1", rsp_valid, 1'b0);
        rvalid = 1'b0;
        @(negedge clk);
        chk("rwait_no_rsp_2", rsp_valid, 1'b0);

        // Randomized accesses against the reference model
        for (int k = 0; k < 40; k++) begin
            logic [2:0] f3;
            logic [31:0] a;
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            txn32(1'($urandom_range(0, 1)), f3, a, $urandom, $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 2),
                  ($urandom_range(0, 7) == 0), got);
        end

        // 64-bit bus: LD aligned, LD misaligned, LW/LWU of the upper word
        txn64(3'b011, 32'h8, 64'h0123456789ABCDEF, 1'b0, 64'h0123456789ABCDEF);
        txn64(3'b011, 32'hC, 64'h0, 1'b1, 64'h0);
        txn64(3'b010, 32'hC, 64'h87654321_00000000, 1'b0, 64'hFFFFFFFF_87654321);
        txn64(3'b110, 32'hC, 64'h87654321_00000000, 1'b0, 64'h00000000_87654321);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
